// File: rtl/instruction_memory_if.sv
// instruction_memory_if: cache-side read bus plus byte-preload port of the instruction memory
interface instruction_memory_if;
    logic         read;
    logic [5:0]   address;
    logic [127:0] readinst;
    logic         busywait;
    logic         prog_en;
    logic [9:0]   prog_addr;
    logic [7:0]   prog_data;
    modport master (output read, address, prog_en, prog_addr, prog_data, input readinst, busywait);
    modport slave  (input read, address, prog_en, prog_addr, prog_data, output readinst, busywait);
endinterface

// File: rtl/instruction_memory.sv
// instruction_memory: 1 KiB block-read memory with fixed LATENCY-edge read delay and byte preload
module instruction_memory #(
    parameter int LATENCY = 5
) (
    input logic                  clock,
    input logic                  reset,
    instruction_memory_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t       state, state_nxt;
    logic [7:0]   mem [0:1023];
    logic [7:0]   cnt, cnt_nxt;
    logic [5:0]   blk, blk_nxt;
    logic         busy_nxt, load;
    logic [127:0] block;
    always_comb begin
        block = '0;
        for (int i = 0; i < 16; i++) block[8*i +: 8] = mem[{blk, 4'(i)}];
    end
    // a preload write takes priority over a read request on the same edge
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        blk_nxt   = blk;
        busy_nxt  = bus.busywait;
        load      = 1'b0;
        case (state)
            IDLE: if (bus.read && !bus.prog_en) begin
                state_nxt = BUSY;
                cnt_nxt   = 8'(LATENCY - 1);
                blk_nxt   = bus.address;
                busy_nxt  = 1'b1;
            end
            BUSY: if (!bus.read) begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end else if (cnt != 8'd0) begin
                cnt_nxt = cnt - 8'd1;
            end else begin
                load      = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            blk          <= '0;
            bus.busywait <= 1'b0;
            bus.readinst <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            blk          <= blk_nxt;
            bus.busywait <= busy_nxt;
            if (load) bus.readinst <= block;
        end
    end
    // contents survive reset so a program loaded once stays valid
    always_ff @(posedge clock) begin
        if (state == IDLE && bus.prog_en) mem[bus.prog_addr] <= bus.prog_data;
    end
endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: checks LATENCY=5 and LATENCY=1 instances against a transaction-level model
module tb_instruction_memory;
    logic clk = 1'b0, rst_n = 1'b0;
    logic read = 1'b0, prog_en = 1'b0;
    logic [5:0] address = '0;
    logic [9:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    int tests = 0, fails = 0, c;
    bit mon = 1'b0;
    localparam logic [127:0] BLK0 = 128'h1F1E1D1C1B1A19181716151413121110;
    localparam logic [127:0] BLK1 = 128'hDCD5CEC7C0B9B2ABA49D968F88817A73;

    always #5 clk = ~clk;

    instruction_memory_if b5();
    instruction_memory_if b1();
    assign b5.read = read;  assign b5.address = address;  assign b5.prog_en = prog_en;
    assign b5.prog_addr = prog_addr;  assign b5.prog_data = prog_data;
    assign b1.read = read;  assign b1.address = address;  assign b1.prog_en = prog_en;
    assign b1.prog_addr = prog_addr;  assign b1.prog_data = prog_data;

    instruction_memory #(.LATENCY(5)) dut5 (.clock(clk), .reset(rst_n), .bus(b5));
    instruction_memory #(.LATENCY(1)) dut1 (.clock(clk), .reset(rst_n), .bus(b1));

    // model: index 0 is the LATENCY=5 instance, index 1 the LATENCY=1 instance
    bit [7:0]     mm [2][1024];
    int           ph [2];
    int           n [2];
    bit [5:0]     mb [2];
    bit           mbusy [2];
    logic [127:0] minst [2];

    function automatic int lat(int k);
        return k == 0 ? 5 : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                ph[k] = 0; n[k] = 0; mbusy[k] = 1'b0; minst[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ph[k] == 0) begin
                    if (prog_en) mm[k][prog_addr] = prog_data;
                    else if (read) begin ph[k] = 1; n[k] = 0; mb[k] = address; mbusy[k] = 1'b1; end
                end else if (ph[k] == 1) begin
                    if (!read) begin ph[k] = 0; mbusy[k] = 1'b0; end
                    else begin
                        n[k]++;
                        if (n[k] == lat(k)) begin
                            for (int i = 0; i < 16; i++) minst[k][8*i +: 8] = mm[k][mb[k]*16 + i];
                            mbusy[k] = 1'b0;
                            ph[k] = 2;
                        end
                    end
                end else ph[k] = 0;
            end
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (mon) begin
        check("busy5", {127'd0, b5.busywait}, {127'd0, mbusy[0]});
        check("inst5", b5.readinst, minst[0]);
        check("busy1", {127'd0, b1.busywait}, {127'd0, mbusy[1]});
        check("inst1", b1.readinst, minst[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_read5(input logic [5:0] a, output int cnt_o);
        read = 1'b1; address = a;
        tick();
        cnt_o = 0;
        while (b5.busywait && cnt_o < 300) begin cnt_o++; tick(); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tick(); tick();
        check("reset_busy", {127'd0, b5.busywait}, 128'd0);
        check("reset_inst", b5.readinst, 128'd0);
        rst_n = 1'b1; mon = 1'b1;
        for (int a = 0; a < 1024; a++) begin
            prog_en = 1'b1; prog_addr = 10'(a);
            prog_data = a < 16 ? 8'(8'h10 + a) : 8'(a * 7 + 3);
            tick();
        end
        prog_en = 1'b0;
        tick();
        // basic read of block 0
        run_read5(6'd0, c);
        check("lat5_cycles", 128'(c), 128'd5);
        check("blk0", b5.readinst, BLK0);
        // read held through DONE: block 1 taken on the edge after DONE
        address = 6'd1;
        tick();
        check("done_not_reaccept", {127'd0, b5.busywait}, 128'd0);
        tick();
        check("b2b_accept", {127'd0, b5.busywait}, 128'd1);
        c = 0;
        while (b5.busywait && c < 300) begin c++; tick(); end
        check("b2b_cycles", 128'(c), 128'd5);
        check("blk1", b5.readinst, BLK1);
        read = 1'b0;
        tick(); tick();
        check("one_return", {127'd0, b5.busywait}, 128'd0);
        // address change and preload attempt while busy are both ignored
        read = 1'b1; address = 6'd0;
        tick(); tick(); tick();
        address = 6'd63; prog_en = 1'b1; prog_addr = 10'd5; prog_data = 8'hEE;
        tick();
        prog_en = 1'b0;
        c = 0;
        while (b5.busywait && c < 300) begin c++; tick(); end
        check("latched_addr", b5.readinst, BLK0);
        read = 1'b0;
        tick();
        // abort after two busy edges
        read = 1'b1; address = 6'd1;
        tick(); tick(); tick();
        read = 1'b0;
        tick();
        check("abort_busy", {127'd0, b5.busywait}, 128'd0);
        check("abort_keep", b5.readinst, BLK0);
        read = 1'b1;
        tick();
        check("abort_idle", {127'd0, b5.busywait}, 128'd1);
        // asynchronous reset in the middle of a read
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {127'd0, b5.busywait}, 128'd0);
        check("rst_inst", b5.readinst, 128'd0);
        read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("rst_no_data", b5.readinst, 128'd0);
        run_read5(6'd0, c);
        check("mem_kept", b5.readinst, BLK0);
        read = 1'b0;
        tick();
        // write wins over read in IDLE, then the read is accepted
        read = 1'b1; address = 6'd63; prog_en = 1'b1; prog_addr = 10'h3F0; prog_data = 8'hAB;
        tick();
        check("wr_wins5", {127'd0, b5.busywait}, 128'd0);
        check("wr_wins1", {127'd0, b1.busywait}, 128'd0);
        prog_en = 1'b0;
        tick();
        check("lat1_busy", {127'd0, b1.busywait}, 128'd1);
        tick();
        check("lat1_done", {127'd0, b1.busywait}, 128'd0);
        check("lat1_byte", {120'd0, b1.readinst[7:0]}, 128'hAB);
        c = 1;
        while (b5.busywait && c < 300) begin c++; tick(); end
        check("lat5_blk63", 128'(c), 128'd5);
        check("blk63_b0", {120'd0, b5.readinst[7:0]}, 128'hAB);
        check("blk63_b1", {120'd0, b5.readinst[15:8]}, 128'h9A);
        check("blk63_b15", {120'd0, b5.readinst[127:120]}, 128'hFC);
        read = 1'b0;
        tick(); tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 5, meaning clock edges from request acceptance to data return; legal range 1..255.
REQ-002 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port read  input  1  block read request from the instruction cache.
REQ-005 SHALL have port address  input  6  block address, 16-byte blocks, 64 blocks.
REQ-006 SHALL have port readinst  output  128  returned block, registered.
REQ-007 SHALL have port busywait  output  1  high while a read is in progress, registered.
REQ-008 SHALL have port prog_en  input  1  byte-load strobe for program preload.
REQ-009 SHALL have port prog_addr  input  10  byte address for preload.
REQ-010 SHALL have port prog_data  input  8  byte value for preload.

Function
REQ-011 SHALL store 1024 bytes; block b byte i (i=0..15) at byte address {b,i} and returned on readinst[8i+7:8i].
REQ-012 SHALL implement states IDLE, BUSY, DONE.
REQ-013 In IDLE, on a rising edge with read=1 and prog_en=0, SHALL latch address, load the down-counter with LATENCY-1, set busywait=1, and go to BUSY.
REQ-014 In BUSY, on each rising edge with read=1: counter nonzero -> decrement; counter zero -> load readinst from the latched block, clear busywait, go to DONE.
REQ-015 SHALL therefore drop busywait and present valid readinst exactly LATENCY edges after the accepting edge.
REQ-016 SHALL ignore changes on address while in BUSY; the latched address is used.
REQ-017 If read=0 on any rising edge in BUSY, SHALL abort: go to IDLE, clear busywait, leave readinst unchanged.
REQ-018 DONE SHALL last exactly one cycle, ignore read, and return to IDLE, so a request still held high on the cache's write-back edge is not re-accepted.
REQ-019 readinst SHALL hold its value until the next completed read or reset.
REQ-020 In IDLE, on a rising edge with prog_en=1, SHALL write prog_data to byte prog_addr.
REQ-021 When prog_en=1 and read=1 together in IDLE, the write SHALL win; the read is not accepted that edge and is accepted on the first later edge with prog_en=0.
REQ-022 SHALL ignore prog_en in BUSY and DONE.
REQ-023 A write to the same byte as a pending read SHALL not be possible; see REQ-022.

Reset
REQ-024 SHALL, while reset=0 and independent of clock, force state=IDLE, busywait=0, readinst=0, counter=0.
REQ-025 Reset asserted mid-read SHALL discard the request; after release no data is returned until a new read is accepted.
REQ-026 Reset SHALL NOT clear memory contents.

Verification
REQ-027 Preload bytes 0x00..0x0F with 0x10..0x1F; read=1, address=0, LATENCY=5 -> busywait high 5 edges, then readinst=0x1F1E..1110, busywait=0.
REQ-028 Back-to-back: read held high through DONE, then address=1 -> block 1 accepted on the edge after DONE, exactly one return per request.
REQ-029 Change address 0->63 two edges after acceptance -> block 0 returned.
REQ-030 Drop read after 2 BUSY edges -> busywait=0 next edge, readinst keeps the previous value, state IDLE.
REQ-031 Assert reset=0 between edges during BUSY -> busywait=0, readinst=0 immediately; memory data still intact on a later read.
REQ-032 prog_en=1 with read=1 in IDLE, prog_addr=0x3F0, prog_data=0xAB, address=63 -> write applied, read accepted next edge, readinst[7:0]=0xAB; LATENCY=1 -> busywait high exactly one edge.
